gpio_walk_checker: RTL and testbench
====================================

Name: gpio_walk_checker

Overview:
Consumer-side stage for the GPIO test pattern generator. It samples the 32 GPIO pins driven with a walking-one sequence, locks onto the sequence and checks every step. It reports lock, sticky fault, per-pin fault mask, error/lap counters and a status LED. It sits on a second board (or in loopback) at the receiving end of the 32-pin harness, in the same 12 MHz clk domain.

Parameters:
WIDTH, 32, number of GPIO lines checked (pattern index wraps at WIDTH-1)
SETTLE_CYCLES, 4, consecutive identical synced samples before a value is accepted (>=1)
TIMEOUT_CYCLES, 24_000_000, max cycles between accepted values in TRACK (2 s at 12 MHz)
ERR_W, 16, width of saturating error and lap counters

Ports:
clk  in  1  12 MHz system clock
reset  in  1  synchronous, active-high reset
gpio_in  in  WIDTH  raw asynchronous pin levels
clear  in  1  single-cycle pulse: clear fault, fault_mask, counters (not lock)
locked  out  1  checker is tracking the sequence
fault  out  1  sticky: at least one mismatch or timeout since reset/clear
timeout_seen  out  1  sticky: at least one fault was a timeout
fault_mask  out  WIDTH  sticky OR of (sample XOR expected) over all mismatches
err_count  out  ERR_W  saturating count of mismatches plus timeouts
lap_count  out  ERR_W  saturating count of clean WIDTH-step laps
exp_index  out  $clog2(WIDTH)  index of next expected high pin
status_led  out  1  toggles per clean lap; held 1 while fault

Behaviour:
- Reset (sync, highest priority): all outputs 0, state HUNT, sync/settle state cleared.
- Input path: 2-FF synchronizer, then settle detect. Accept event = synced value unchanged for SETTLE_CYCLES consecutive cycles. It fires once per distinct value and does not re-fire while the value holds. Pin change to registered result: SETTLE_CYCLES+2 cycles (6 at default).
- Sample is "one-hot" when exactly one bit is set; idx = position of that bit.
- HUNT: accepted one-hot -> exp_index = (idx+1) mod WIDTH, locked=1, timeout counter=0, go TRACK. Non-one-hot accepts (e.g. all-zero during generator reset) are ignored. No timeout in HUNT.
- TRACK, accepted sample == 1<<exp_index: exp_index increments (WIDTH-1 wraps to 0), timeout counter=0. On the wrap step, if no error occurred during that lap, lap_count++ (saturating) and status_led toggles.
- TRACK, accepted sample != expected: err_count++ (saturating at 2^ERR_W-1), fault_mask |= sample ^ (1<<exp_index), fault=1, locked=0, go HUNT. The mismatching sample is not reused for relock.
- TRACK timeout: counter reaches TIMEOUT_CYCLES-1 with no accept -> err_count++, fault=1, timeout_seen=1, locked=0, go HUNT. fault_mask is unchanged.
- status_led is forced 1 while fault=1. Its toggle state resumes from 0 after clear.
- clear: zeroes fault, timeout_seen, fault_mask, err_count, lap_count and status_led. State, locked and exp_index are untouched. Counters keep clear/event priority as follows: if an error event coincides with clear, the error is applied after clear (err_count=1, fault=1, mask = that mismatch only).
- A lap in which an error occurred is not counted. The lap-clean flag resets at each relock and each wrap.
- exp_index holds its last value in HUNT.

Decomposition:
- gpiotest_pkg: GPIO_WIDTH=32, CLK_HZ=12_000_000, checker state enum (HUNT, TRACK), onehot/index helper function.
- Sub-module gpio_settle: synchronizer plus settle detect. Outputs the stable WIDTH-bit value and an accept pulse.
- gpio_walk_checker contains the FSM, counters and LED logic.

Test Plan:
- Walk 0..31 then 0..31 again, 100 cycles/step, from reset -> locked after the first step is accepted; err_count=0; lap_count=1 after the second wrap; status_led toggled once; fault=0.
- Pin 7 stuck high (OR 0x80 into every step) -> first TRACK accept mismatches; fault=1; fault_mask bit 7 set; err_count=1; the checker never reaches lock-and-pass on a lap while the fault persists.
- Stop the pattern mid-lap at step 12 with TIMEOUT_CYCLES=1000 -> exactly 1000 cycles after the last accept: timeout_seen=1, err_count=1, locked=0, fault_mask=0. Resuming the pattern relocks.
- Glitch: a 2-cycle pulse of 0x0000_0001 between steps (shorter than SETTLE_CYCLES) -> no accept, no error, exp_index unaffected.
- Pulse clear in the same cycle as a mismatch accept -> err_count=1, fault=1, lap_count=0.
- Assert reset mid-TRACK at exp_index=20 -> next cycle all outputs 0 and state HUNT. The next one-hot accept relocks with exp_index=(idx+1) mod 32.

Source files
------------

// File: rtl/gpiotest_pkg.sv
// Shared types and helpers for the GPIO walking-one test pattern blocks.
package gpiotest_pkg;

   localparam int unsigned GPIO_WIDTH = 32;
   localparam int unsigned CLK_HZ     = 12_000_000;
   localparam int unsigned GPIO_IDX_W = $clog2(GPIO_WIDTH);

   typedef enum logic {
      ST_HUNT  = 1'b0,
      ST_TRACK = 1'b1
   } chk_state_t;

   typedef struct packed {
      logic                  valid;
      logic [GPIO_IDX_W-1:0] idx;
   } onehot_t;

   // valid when exactly one bit is set; idx is the position of that bit
   function automatic onehot_t onehot_decode(input logic [GPIO_WIDTH-1:0] v);
      onehot_t res;
      res.valid = ($countones(v) == 1);
      res.idx   = '0;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
         if (v[i]) res.idx = GPIO_IDX_W'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/gpio_walk_checker_settle.sv
// Two-flop synchronizer followed by a settle detector that pulses once per
// newly stable value.
module gpio_settle
   import gpiotest_pkg::*;
#(
   parameter int unsigned WIDTH         = GPIO_WIDTH,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_gpio,
   output logic [WIDTH-1:0] o_value,
   output logic             o_accept_c
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_last;
   logic [CNT_W-1:0] r_run;
   logic             w_same;
   logic [CNT_W-1:0] w_run;

   // run length of the synced value including the current cycle, capped
   assign w_same = (r_sync == r_last);
   assign w_run  = !w_same                             ? CNT_W'(1) :
                   (r_run == CNT_W'(SETTLE_CYCLES))    ? r_run     :
                                                         r_run + CNT_W'(1);

   // a saturated run that is still unchanged must not fire again
   assign o_accept_c = (w_run == CNT_W'(SETTLE_CYCLES)) &&
                       !(w_same && (r_run == CNT_W'(SETTLE_CYCLES)));
   assign o_value    = r_sync;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= '0;
         r_sync <= '0;
         r_last <= '0;
         r_run  <= '0;
      end else begin
         r_meta <= i_gpio;
         r_sync <= r_meta;
         r_last <= r_sync;
         r_run  <= w_run;
      end
   end

endmodule

// File: rtl/gpio_walk_checker.sv
// Receiving end of the GPIO walking-one harness: locks onto the sequence,
// checks each step and keeps sticky fault, counters and a status LED.
module gpio_walk_checker
   import gpiotest_pkg::*;
#(
   parameter int unsigned WIDTH          = GPIO_WIDTH,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 24_000_000,
   parameter int unsigned ERR_W          = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [WIDTH-1:0]         i_gpio_in,
   input  logic                     i_clear,
   output logic                     o_locked,
   output logic                     o_fault,
   output logic                     o_timeout_seen,
   output logic [WIDTH-1:0]         o_fault_mask,
   output logic [ERR_W-1:0]         o_err_count,
   output logic [ERR_W-1:0]         o_lap_count,
   output logic [$clog2(WIDTH)-1:0] o_exp_index,
   output logic                     o_status_led
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

   chk_state_t       r_state;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_lap_clean;
   logic             r_led_tgl;
   logic             r_locked;
   logic             r_fault;
   logic             r_timeout_seen;
   logic [WIDTH-1:0] r_fault_mask;
   logic [ERR_W-1:0] r_err_count;
   logic [ERR_W-1:0] r_lap_count;
   logic [IDX_W-1:0] r_exp_index;
   logic             r_status_led;

   logic [WIDTH-1:0] w_value;
   logic             w_accept;
   onehot_t          w_dec;
   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_expected;
   logic             w_in_track;
   logic             w_match;
   logic             w_mismatch;
   logic             w_timeout;
   logic             w_relock;
   logic             w_wrap;
   logic             w_lap;
   logic [ERR_W-1:0] w_err_base;
   logic [ERR_W-1:0] w_lap_base;
   logic [ERR_W-1:0] w_err_next;
   logic [ERR_W-1:0] w_lap_next;
   logic [WIDTH-1:0] w_mask_next;
   logic             w_fault_next;
   logic             w_tos_next;
   logic             w_tgl_next;

   gpio_settle #(
      .WIDTH         (WIDTH),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_gpio     (i_gpio_in),
      .o_value    (w_value),
      .o_accept_c (w_accept)
   );

   assign w_dec      = onehot_decode(GPIO_WIDTH'(w_value));
   assign w_idx      = IDX_W'(w_dec.idx);
   assign w_expected = WIDTH'(1) << r_exp_index;

   assign w_in_track = (r_state == ST_TRACK);
   assign w_match    = w_accept && w_in_track && (w_value == w_expected);
   assign w_mismatch = w_accept && w_in_track && (w_value != w_expected);
   assign w_timeout  = w_in_track && !w_accept && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_relock   = w_accept && !w_in_track && w_dec.valid;
   assign w_wrap     = w_match && (r_exp_index == IDX_W'(WIDTH - 1));
   assign w_lap      = w_wrap && r_lap_clean;

   // clear is applied first, then any event landing in the same cycle
   assign w_err_base   = i_clear ? '0 : r_err_count;
   assign w_lap_base   = i_clear ? '0 : r_lap_count;
   assign w_err_next   = ((w_mismatch || w_timeout) && (w_err_base != '1)) ?
                         w_err_base + ERR_W'(1) : w_err_base;
   assign w_lap_next   = (w_lap && (w_lap_base != '1)) ? w_lap_base + ERR_W'(1) : w_lap_base;
   assign w_mask_next  = (i_clear ? '0 : r_fault_mask) |
                         (w_mismatch ? (w_value ^ w_expected) : '0);
   assign w_fault_next = (r_fault && !i_clear) || w_mismatch || w_timeout;
   assign w_tos_next   = (r_timeout_seen && !i_clear) || w_timeout;
   assign w_tgl_next   = (i_clear ? 1'b0 : r_led_tgl) ^ w_lap;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_HUNT;
         r_to_cnt       <= '0;
         r_lap_clean    <= 1'b0;
         r_led_tgl      <= 1'b0;
         r_locked       <= 1'b0;
         r_fault        <= 1'b0;
         r_timeout_seen <= 1'b0;
         r_fault_mask   <= '0;
         r_err_count    <= '0;
         r_lap_count    <= '0;
         r_exp_index    <= '0;
         r_status_led   <= 1'b0;
      end else begin
         r_fault        <= w_fault_next;
         r_timeout_seen <= w_tos_next;
         r_fault_mask   <= w_mask_next;
         r_err_count    <= w_err_next;
         r_lap_count    <= w_lap_next;
         r_led_tgl      <= w_tgl_next;
         r_status_led   <= w_fault_next | w_tgl_next;

         if (r_state == ST_HUNT) begin
            // the lap in progress at lock time is partial, so it never counts
            if (w_relock) begin
               r_exp_index <= (w_idx == IDX_W'(WIDTH - 1)) ? '0 : w_idx + IDX_W'(1);
               r_locked    <= 1'b1;
               r_to_cnt    <= '0;
               r_lap_clean <= 1'b0;
               r_state     <= ST_TRACK;
            end
         end else begin
            if (w_match) begin
               r_exp_index <= w_wrap ? '0 : r_exp_index + IDX_W'(1);
               r_to_cnt    <= '0;
               if (w_wrap) r_lap_clean <= 1'b1;
            end else if (w_mismatch || w_timeout) begin
               r_locked <= 1'b0;
               r_state  <= ST_HUNT;
            end else begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
            end
         end
      end
   end

   assign o_locked       = r_locked;
   assign o_fault        = r_fault;
   assign o_timeout_seen = r_timeout_seen;
   assign o_fault_mask   = r_fault_mask;
   assign o_err_count    = r_err_count;
   assign o_lap_count    = r_lap_count;
   assign o_exp_index    = r_exp_index;
   assign o_status_led   = r_status_led;

endmodule

// File: tb/tb_gpio_walk_checker.sv
// Randomized bench for gpio_walk_checker against an event-level model of the
// walking-one checking rules.
module tb_gpio_walk_checker;

   localparam int unsigned W       = 32;
   localparam int unsigned SETTLE  = 4;
   localparam int unsigned TIMEOUT = 1000;
   localparam int unsigned EW      = 16;
   localparam int          SAT     = 65535;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [W-1:0]  pins;
   logic          locked, fault, tos, led;
   logic [W-1:0]  mask;
   logic [EW-1:0] errc, lapc;
   logic [4:0]    expi;

   gpio_walk_checker #(
      .WIDTH          (W),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT),
      .ERR_W          (EW)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_gpio_in      (pins),
      .i_clear        (clr),
      .o_locked       (locked),
      .o_fault        (fault),
      .o_timeout_seen (tos),
      .o_fault_mask   (mask),
      .o_err_count    (errc),
      .o_lap_count    (lapc),
      .o_exp_index    (expi),
      .o_status_led   (led)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // accepted values with the clock edge at which the checker consumes them
   typedef struct {
      int         t;
      logic [W-1:0] v;
   } acc_t;
   acc_t acc_q[$];

   // model of the pins as seen by the settle stage
   logic [W-1:0] m_cur;
   int           m_run_start;
   bit           m_acc_done;

   // model of the checker outputs
   bit           m_track, m_locked, m_fault, m_tos, m_tgl, m_full;
   logic [W-1:0] m_mask;
   int           m_err, m_lap, m_exp, m_last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic m_err_event();
      if (m_err < SAT) m_err++;
      m_fault  = 1'b1;
      m_locked = 1'b0;
      m_track  = 1'b0;
   endtask

   task automatic m_accept(input logic [W-1:0] v, input int t);
      int k;
      logic [W-1:0] e;
      e = W'(1) << m_exp;
      if (!m_track) begin
         if ($countones(v) == 1) begin
            k = 0;
            for (int i = 0; i < W; i++) if (v[i]) k = i;
            m_exp    = (k + 1) % W;
            m_track  = 1'b1;
            m_locked = 1'b1;
            m_last   = t;
            m_full   = 1'b0;
         end
      end else if (v == e) begin
         m_last = t;
         if (m_exp == W - 1) begin
            if (m_full) begin
               if (m_lap < SAT) m_lap++;
               m_tgl = !m_tgl;
            end
            m_full = 1'b1;
            m_exp  = 0;
         end else begin
            m_exp++;
         end
      end else begin
         m_mask = m_mask | (v ^ e);
         m_err_event();
      end
   endtask

   // apply every accept and timeout falling on or before edge t, in time order
   task automatic m_advance(input int t);
      bit have_a;
      int tt;
      forever begin
         have_a = (acc_q.size() > 0) && (acc_q[0].t <= t);
         tt     = m_last + TIMEOUT;
         if (m_track && (tt <= t) && (!have_a || (tt < acc_q[0].t))) begin
            m_tos = 1'b1;
            m_err_event();
         end else if (have_a) begin
            m_accept(acc_q[0].v, acc_q[0].t);
            void'(acc_q.pop_front());
         end else begin
            break;
         end
      end
   endtask

   task automatic m_clear();
      m_fault = 1'b0;
      m_tos   = 1'b0;
      m_mask  = '0;
      m_err   = 0;
      m_lap   = 0;
      m_tgl   = 1'b0;
   endtask

   task automatic set_pins(input logic [W-1:0] v, input int hold);
      acc_t a;
      if (v !== m_cur) begin
         m_cur       = v;
         m_run_start = cyc;
         m_acc_done  = 1'b0;
      end
      if (!m_acc_done && (cyc + hold - m_run_start >= SETTLE)) begin
         a.t = m_run_start + SETTLE + 2;
         a.v = v;
         acc_q.push_back(a);
         m_acc_done = 1'b1;
      end
      pins = v;
   endtask

   task automatic drive(input logic [W-1:0] v, input int hold);
      m_advance(cyc);
      set_pins(v, hold);
      run(hold);
   endtask

   task automatic pulse_clear();
      m_advance(cyc);
      m_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic do_reset();
      m_advance(cyc);
      rst = 1'b1;
      step();
      rst = 1'b0;
      acc_q.delete();
      m_track = 0; m_locked = 0; m_fault = 0; m_tos = 0; m_tgl = 0; m_full = 0;
      m_mask = '0; m_err = 0; m_lap = 0; m_exp = 0; m_last = 0;
      m_cur       = pins;
      m_run_start = cyc;
      m_acc_done  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      m_advance(cyc);
      chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
      chk({tag, ".fault"},  32'(fault),  32'(m_fault));
      chk({tag, ".tos"},    32'(tos),    32'(m_tos));
      chk({tag, ".mask"},   mask,        m_mask);
      chk({tag, ".err"},    32'(errc),   32'(m_err));
      chk({tag, ".lap"},    32'(lapc),   32'(m_lap));
      chk({tag, ".exp"},    32'(expi),   32'(m_exp));
      chk({tag, ".led"},    32'(led),    32'(m_fault | m_tgl));
   endtask

   initial begin
      int ta;
      int k;
      logic [W-1:0] v;

      rst  = 1'b1;
      clr  = 1'b0;
      pins = '0;
      step();
      do_reset();
      check_all("reset");
      drive('0, 20);
      check_all("idle");

      // two clean laps, with a short glitch before step 10 of the second lap
      for (int lap = 0; lap < 2; lap++) begin
         for (int s = 0; s < W; s++) begin
            if (lap == 1 && s == 10) begin
               drive(W'(1), 2);
               check_all("glitch");
            end
            drive(W'(1) << s, 100);
            check_all($sformatf("walk%0d_%0d", lap, s));
         end
      end
      chk("lap_after_two", 32'(lapc), 32'd1);
      chk("led_after_two", 32'(led), 32'd1);

      // stop mid-lap at step 12 and let the timeout expire
      for (int s = 0; s < 12; s++) drive(W'(1) << s, $urandom_range(20, 150));
      m_advance(cyc);
      ta = cyc + SETTLE + 2;
      set_pins(W'(1) << 12, 2000);
      run(ta + TIMEOUT - 1 - cyc);
      check_all("to_pre");
      run(1);
      check_all("to_hit");
      chk("to_tos", 32'(tos), 32'd1);
      drive(W'(1) << 13, 100);
      check_all("to_relock");

      pulse_clear();
      check_all("clear");

      // pin 7 stuck high across more than a lap
      for (int s = 14; s < 14 + W + 4; s++) begin
         drive((W'(1) << (s % W)) | W'(32'h80), $urandom_range(20, 150));
         check_all($sformatf("stuck_%0d", s % W));
      end

      // clear coinciding with a mismatch accept
      pulse_clear();
      for (int s = 0; s < 4; s++) drive(W'(1) << s, 60);
      check_all("pre_clr_err");
      m_advance(cyc);
      set_pins(W'(1) << 9, 100);
      run(SETTLE + 1);
      pulse_clear();
      run(94);
      check_all("clr_err");

      // reset mid-track at exp_index 20
      for (int s = 0; s < 20; s++) drive(W'(1) << s, 60);
      check_all("pre_rst");
      do_reset();
      check_all("rst_mid");
      drive(W'(1) << 19, 100);
      check_all("rst_relock");

      // relock from reset on random pins, including the wrap index
      for (int i = 0; i < 4; i++) begin
         k = (i == 0) ? 31 : int'($urandom_range(0, 31));
         drive(W'(1) << k, 40);
         do_reset();
         drive(W'(1) << k, $urandom_range(20, 120));
         check_all($sformatf("rnd_lock_%0d", k));
      end

      // random walk with occasional glitches and wrong values
      for (int i = 0; i < 80; i++) begin
         m_advance(cyc);
         if ($urandom_range(0, 4) == 0) drive(W'(1), $urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) v = W'($urandom);
         else                            v = W'(1) << m_exp;
         drive(v, $urandom_range(20, 150));
         check_all($sformatf("rnd_%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
